// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Definitions shared by the memory read and write paths.
//               - store FSM state encoding
//               - memory target select codes
//               - halfword count-code decode
//               - memory port and address widths
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int MEM_WIDTH  = 16;
    localparam int ADDR_WIDTH = 32;

    // CTRL[0] selects which memory receives the halfwords.
    localparam logic TGT_KERNEL = 1'b0;
    localparam logic TGT_PIC    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAIL  = 2'd3
    } store_state_t;

    // CTRL[2:1] -> number of halfwords to write.
    // The reserved code 11 behaves like a full 3-halfword store.
    function automatic logic [1:0] decode_count(input logic [1:0] code);
        logic [1:0] n;
        n = 2'd3;
        case (code)
            2'b00:   n = 2'd1;
            2'b01:   n = 2'd2;
            default: n = 2'd3;
        endcase
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/halfword_serializer.sv
// ============================================================================
// Module      : halfword_serializer
// Description : Holds a latched store word and hands it out one halfword at a
//               time, lowest halfword first.
// Ports       : CLK, RESET     - clock, asynchronous active-low reset
//               load           - capture data_in / count_in
//               data_in        - full store word
//               count_in       - number of halfwords to emit (1..3)
//               advance        - current halfword accepted, move to next
//               data_lo        - current halfword (registered)
//               last           - current halfword is the final one
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module halfword_serializer
    import mem_pkg::*;
#(
    parameter int MEM_W  = MEM_WIDTH,
    parameter int DATA_W = 3 * MEM_WIDTH
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        count_in,
    input  logic              advance,
    output logic [MEM_W-1:0]  data_lo,
    output logic              last
);

    logic [DATA_W-1:0] shift_q;
    logic [1:0]        remain_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            shift_q  <= '0;
            remain_q <= 2'd0;
        end else if (load) begin
            shift_q  <= data_in;
            remain_q <= count_in;
        end else if (advance) begin
            // Zero-fill from the top so the next halfword lands in the low slice.
            shift_q  <= {{MEM_W{1'b0}}, shift_q[DATA_W-1:MEM_W]};
            remain_q <= remain_q - 2'd1;
        end
    end

    // The low slice of the shift register is itself a flop, so the memory
    // data output stays fully registered.
    assign data_lo = shift_q[MEM_W-1:0];
    assign last    = (remain_q == 2'd1);

endmodule

`default_nettype wire

// File: rtl/memory_store.sv
// ============================================================================
// Module      : memory_store
// Description : Store path from the MEM stage. Splits a 48-bit store into
//               16-bit halfwords and writes them to the kernel or picture
//               memory, one write/acknowledge exchange per halfword.
// Ports       : CLK, RESET     - clock, asynchronous active-low reset
//               ENABLE         - request level, held for the transaction
//               CTRL           - [0] target, [2:1] halfword count code
//               ADDRESS        - [31:0] first halfword address
//               WRITE          - store data, [15:0] written first
//               HANDSHAKE      - store complete, held until ENABLE low
//               ERROR          - acknowledge timeout, held until ENABLE low
//               MEM_K_WE/P_WE  - kernel / picture write strobes
//               MEM_ADDRESS    - halfword address
//               MEM_WDATA      - halfword data
//               MEM_ACK        - memory accepted the current halfword
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_store
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_WIDTH,
    parameter int DATA_W      = 3 * MEM_WIDTH,
    parameter int MEM_W       = MEM_WIDTH,
    parameter int ACK_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [2:0]        CTRL,
    input  logic [DATA_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WRITE,
    output logic              HANDSHAKE,
    output logic              ERROR,
    output logic              MEM_K_WE,
    output logic              MEM_P_WE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [MEM_W-1:0]  MEM_WDATA,
    input  logic              MEM_ACK
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    store_state_t    state;
    logic [TO_W-1:0] to_cnt;
    logic            last;
    logic            ser_load;
    logic            ser_advance;

    // Upper address bits of the request bus carry nothing for the store.
    logic            unused_addr_hi;
    assign unused_addr_hi = ^ADDRESS[DATA_W-1:ADDR_W];

    assign ser_load    = (state == ST_IDLE) && ENABLE;
    assign ser_advance = (state == ST_ISSUE) && ENABLE && MEM_ACK && !last;

    halfword_serializer #(
        .MEM_W  (MEM_W),
        .DATA_W (DATA_W)
    ) u_serializer (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (ser_load),
        .data_in  (WRITE),
        .count_in (decode_count(CTRL[2:1])),
        .advance  (ser_advance),
        .data_lo  (MEM_WDATA),
        .last     (last)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= ST_IDLE;
            to_cnt      <= '0;
            HANDSHAKE   <= 1'b0;
            ERROR       <= 1'b0;
            MEM_K_WE    <= 1'b0;
            MEM_P_WE    <= 1'b0;
            MEM_ADDRESS <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    HANDSHAKE <= 1'b0;
                    ERROR     <= 1'b0;
                    if (ENABLE) begin
                        MEM_ADDRESS <= ADDRESS[ADDR_W-1:0];
                        MEM_K_WE    <= (CTRL[0] == TGT_KERNEL);
                        MEM_P_WE    <= (CTRL[0] == TGT_PIC);
                        to_cnt      <= '0;
                        state       <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // Abort beats a simultaneous ACK; ACK beats timeout expiry.
                    if (!ENABLE) begin
                        MEM_K_WE <= 1'b0;
                        MEM_P_WE <= 1'b0;
                        to_cnt   <= '0;
                        state    <= ST_IDLE;
                    end else if (MEM_ACK) begin
                        to_cnt <= '0;
                        if (last) begin
                            MEM_K_WE <= 1'b0;
                            MEM_P_WE <= 1'b0;
                            state    <= ST_DONE;
                        end else begin
                            MEM_ADDRESS <= MEM_ADDRESS + 1'b1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        MEM_K_WE <= 1'b0;
                        MEM_P_WE <= 1'b0;
                        to_cnt   <= '0;
                        state    <= ST_FAIL;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (!ENABLE) begin
                        HANDSHAKE <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        HANDSHAKE <= 1'b1;
                    end
                end

                ST_FAIL: begin
                    HANDSHAKE <= 1'b0;
                    if (!ENABLE) begin
                        ERROR <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        ERROR <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_store.sv
// ============================================================================
// Module      : tb_memory_store
// Description : Directed self-checking bench for memory_store.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_store;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic [2:0]  CTRL;
    logic [47:0] ADDRESS;
    logic [47:0] WRITE;
    logic        HANDSHAKE;
    logic        ERROR;
    logic        MEM_K_WE;
    logic        MEM_P_WE;
    logic [31:0] MEM_ADDRESS;
    logic [15:0] MEM_WDATA;
    logic        MEM_ACK;

    int checks = 0;
    int errors = 0;

    memory_store dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ENABLE      (ENABLE),
        .CTRL        (CTRL),
        .ADDRESS     (ADDRESS),
        .WRITE       (WRITE),
        .HANDSHAKE   (HANDSHAKE),
        .ERROR       (ERROR),
        .MEM_K_WE    (MEM_K_WE),
        .MEM_P_WE    (MEM_P_WE),
        .MEM_ADDRESS (MEM_ADDRESS),
        .MEM_WDATA   (MEM_WDATA),
        .MEM_ACK     (MEM_ACK)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic k, input logic p,
                            input logic [31:0] a, input logic [15:0] d,
                            input logic hs, input logic er);
        chk({tag, ".k_we"}, 64'(MEM_K_WE), 64'(k));
        chk({tag, ".p_we"}, 64'(MEM_P_WE), 64'(p));
        chk({tag, ".addr"}, 64'(MEM_ADDRESS), 64'(a));
        chk({tag, ".wdata"}, 64'(MEM_WDATA), 64'(d));
        chk({tag, ".hs"}, 64'(HANDSHAKE), 64'(hs));
        chk({tag, ".err"}, 64'(ERROR), 64'(er));
    endtask

    initial begin
        RESET   = 1'b0;
        ENABLE  = 1'b0;
        CTRL    = 3'b000;
        ADDRESS = '0;
        WRITE   = '0;
        MEM_ACK = 1'b0;

        // Reset state
        #12;
        chk_outs("reset", 0, 0, 32'h0, 16'h0, 0, 0);
        @(negedge CLK);
        RESET = 1'b1;

        // 1: kernel, 3 halfwords, ACK tied high
        ENABLE  = 1'b1;
        CTRL    = 3'b100;
        ADDRESS = 48'h0000_0000_0100;
        WRITE   = 48'hCCCC_BBBB_AAAA;
        MEM_ACK = 1'b1;
        tick();
        chk_outs("t1.hw0", 1, 0, 32'h100, 16'hAAAA, 0, 0);
        // Inputs changed after latching must be ignored.
        ADDRESS = 48'h0000_DEAD_BEEF;
        WRITE   = 48'h1111_2222_3333;
        CTRL    = 3'b001;
        tick();
        chk_outs("t1.hw1", 1, 0, 32'h101, 16'hBBBB, 0, 0);
        tick();
        chk_outs("t1.hw2", 1, 0, 32'h102, 16'hCCCC, 0, 0);
        tick();
        chk("t1.we_off_k", 64'(MEM_K_WE), 64'(0));
        chk("t1.hs_gap", 64'(HANDSHAKE), 64'(0));
        tick();
        chk("t1.hs", 64'(HANDSHAKE), 64'(1));
        chk("t1.p_we", 64'(MEM_P_WE), 64'(0));
        ENABLE = 1'b0;
        tick();
        chk("t1.hs_rel", 64'(HANDSHAKE), 64'(0));

        // 2: pic, 1 halfword, ACK delayed 5 cycles
        ENABLE  = 1'b1;
        CTRL    = 3'b001;
        ADDRESS = 48'h0000_0000_0020;
        WRITE   = 48'h0000_0000_1234;
        MEM_ACK = 1'b0;
        tick();
        chk_outs("t2.issue", 0, 1, 32'h20, 16'h1234, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_outs("t2.hold", 0, 1, 32'h20, 16'h1234, 0, 0);
        end
        MEM_ACK = 1'b1;
        tick();
        chk("t2.we_off", 64'(MEM_P_WE), 64'(0));
        MEM_ACK = 1'b0;
        tick();
        chk("t2.hs", 64'(HANDSHAKE), 64'(1));
        tick();
        chk("t2.hs_held", 64'(HANDSHAKE), 64'(1));
        ENABLE = 1'b0;
        tick();
        chk("t2.hs_rel", 64'(HANDSHAKE), 64'(0));

        // 3: address wrap, 2 halfwords
        ENABLE  = 1'b1;
        CTRL    = 3'b010;
        ADDRESS = 48'h0000_FFFF_FFFF;
        WRITE   = 48'h0000_5678_9ABC;
        MEM_ACK = 1'b1;
        tick();
        chk_outs("t3.hw0", 1, 0, 32'hFFFF_FFFF, 16'h9ABC, 0, 0);
        tick();
        chk_outs("t3.hw1", 1, 0, 32'h0000_0000, 16'h5678, 0, 0);
        tick();
        chk("t3.we_off", 64'(MEM_K_WE), 64'(0));
        tick();
        chk("t3.hs", 64'(HANDSHAKE), 64'(1));
        ENABLE = 1'b0;
        tick();

        // 4: ACK never arrives -> timeout after 15 cycles
        ENABLE  = 1'b1;
        CTRL    = 3'b000;
        ADDRESS = 48'h0000_0000_0040;
        WRITE   = 48'h0000_0000_4444;
        MEM_ACK = 1'b0;
        tick();
        chk("t4.we_on", 64'(MEM_K_WE), 64'(1));
        for (int i = 0; i < 14; i++) tick();
        chk("t4.we_cycle15", 64'(MEM_K_WE), 64'(1));
        tick();
        chk("t4.we_drop", 64'(MEM_K_WE), 64'(0));
        tick();
        chk("t4.err", 64'(ERROR), 64'(1));
        chk("t4.hs", 64'(HANDSHAKE), 64'(0));
        ENABLE = 1'b0;
        tick();
        chk("t4.err_rel", 64'(ERROR), 64'(0));

        // 4b: ACK on the same edge the timeout would expire -> ACK wins
        ENABLE  = 1'b1;
        CTRL    = 3'b001;
        ADDRESS = 48'h0000_0000_0050;
        WRITE   = 48'h0000_0000_5555;
        MEM_ACK = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) tick();
        MEM_ACK = 1'b1;
        tick();
        chk("t4b.we_off", 64'(MEM_P_WE), 64'(0));
        MEM_ACK = 1'b0;
        tick();
        chk("t4b.hs", 64'(HANDSHAKE), 64'(1));
        chk("t4b.err", 64'(ERROR), 64'(0));
        ENABLE = 1'b0;
        tick();

        // 5: abort after first ACK, ACK on the aborting edge
        ENABLE  = 1'b1;
        CTRL    = 3'b100;
        ADDRESS = 48'h0000_0000_0200;
        WRITE   = 48'h3333_2222_1111;
        MEM_ACK = 1'b1;
        tick();
        chk_outs("t5.hw0", 1, 0, 32'h200, 16'h1111, 0, 0);
        tick();
        chk_outs("t5.hw1", 1, 0, 32'h201, 16'h2222, 0, 0);
        ENABLE = 1'b0;
        tick();
        chk_outs("t5.abort", 0, 0, 32'h201, 16'h2222, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk_outs("t5.idle", 0, 0, 32'h201, 16'h2222, 0, 0);
        ENABLE  = 1'b1;
        CTRL    = 3'b000;
        ADDRESS = 48'h0000_0000_0300;
        WRITE   = 48'h0000_0000_7777;
        tick();
        chk_outs("t5.new", 1, 0, 32'h300, 16'h7777, 0, 0);
        tick();
        chk("t5.new_off", 64'(MEM_K_WE), 64'(0));
        tick();
        chk("t5.new_hs", 64'(HANDSHAKE), 64'(1));
        ENABLE = 1'b0;
        tick();

        // 6: asynchronous reset mid-ISSUE
        ENABLE  = 1'b1;
        CTRL    = 3'b001;
        ADDRESS = 48'h0000_0000_0055;
        WRITE   = 48'h0000_0000_6666;
        MEM_ACK = 1'b0;
        tick();
        chk("t6.issue", 64'(MEM_P_WE), 64'(1));
        #2;
        RESET  = 1'b0;
        ENABLE = 1'b0;
        #1;
        chk_outs("t6.async", 0, 0, 32'h0, 16'h0, 0, 0);
        #3;
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_outs("t6.post", 0, 0, 32'h0, 16'h0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_store.md
Name: memory_store

Overview:
- Write-direction counterpart of the pipeline's memory read path.
- Accepts a store request from the MEM stage: 48-bit data, 32-bit address, 3-bit CTRL. Splits the data into 16-bit halfwords and writes them to either the kernel memory or the picture memory over a per-halfword write/acknowledge interface.
- Returns a level HANDSHAKE to the pipeline when all halfwords are committed, or ERROR if memory stops acknowledging.

Parameters:
- ADDR_W, 32, request/memory address width
- DATA_W, 48, request data width (must equal 3*MEM_W)
- MEM_W, 16, memory data port width
- ACK_TIMEOUT, 15, max cycles to wait for MEM_ACK per halfword (1..2^TO_W-1)
- TO_W, 4, timeout counter width

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- ENABLE  in  1  request level; held high for the whole transaction
- CTRL  in  3  [0]=target (0 kernel, 1 pic); [2:1]=halfword count code
- ADDRESS  in  48  only [31:0] used; halfword address of first write
- WRITE  in  48  store data; [15:0] first, [31:16] second, [47:32] third
- HANDSHAKE  out  1  store complete; held until ENABLE low
- ERROR  out  1  ack timeout; held until ENABLE low
- MEM_K_WE  out  1  kernel memory write strobe
- MEM_P_WE  out  1  pic memory write strobe
- MEM_ADDRESS  out  32  halfword address
- MEM_WDATA  out  16  halfword data
- MEM_ACK  in  1  memory accepted current halfword (sampled at CLK rise)

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE. All outputs 0, MEM_ADDRESS=0, MEM_WDATA=0. Internal count and timeout registers 0.
- All outputs are registered.
- Count code CTRL[2:1]:
  - 00 → 1 halfword
  - 01 → 2 halfwords
  - 10 → 3 halfwords
  - 11 → reserved, treated as 3
- States: IDLE, ISSUE, DONE, FAIL.
- IDLE:
  - ENABLE=1 at an edge → latch ADDRESS[31:0], WRITE, CTRL[0] and the count.
  - Drive MEM_ADDRESS=ADDRESS, MEM_WDATA=WRITE[15:0].
  - Assert the selected WE (MEM_K_WE if CTRL[0]=0, else MEM_P_WE) and go to ISSUE.
  - Inputs are ignored after latching; later changes to ADDRESS/WRITE/CTRL have no effect.
- ISSUE: WE held high; address and data are stable until acknowledged.
  - MEM_ACK=1 at an edge with halfwords remaining → increment MEM_ADDRESS by 1 (mod 2^32; 0xFFFFFFFF wraps to 0) and present the next data slice. WE stays high (back-to-back), timeout counter clears.
  - MEM_ACK=1 on the last halfword → WE low, go to DONE.
  - MEM_ACK=0 → timeout counter increments. When it reaches ACK_TIMEOUT: WE low, go to FAIL.
- DONE: HANDSHAKE=1. ENABLE=0 → HANDSHAKE=0, go to IDLE.
- FAIL: ERROR=1, HANDSHAKE=0. ENABLE=0 → ERROR=0, go to IDLE.
- ENABLE=0 in ISSUE (abort):
  - Next edge: WE=0, go to IDLE.
  - Halfwords already acknowledged stay written; HANDSHAKE never asserts.
  - ENABLE=0 takes priority over a simultaneous MEM_ACK.
- Simultaneous MEM_ACK and timeout expiry on the same edge: the ACK wins.
- MEM_ACK while not in ISSUE: ignored.
- Only one WE is ever high; never both.
- Latency with MEM_ACK tied high: ENABLE sampled at edge 0 → HANDSHAKE high after edge N+1 (N = halfword count). So 2 cycles for 1 halfword, 4 cycles for 3 halfwords.
- A new request requires ENABLE to return low for at least one cycle (IDLE).

Decomposition:
- Shared package mem_pkg:
  - state enum (IDLE, ISSUE, DONE, FAIL)
  - target select constants (TGT_KERNEL=0, TGT_PIC=1)
  - count-code decode function
  - MEM_W/ADDR_W constants, shared with the read path
- Sub-module halfword_serializer:
  - holds the latched 48-bit data and remaining count
  - shifts out 16 bits per ACK
  - reports last-halfword
- The FSM and timeout counter live in memory_store.

Test Plan:
1. CTRL=3'b100 (kernel, 3 halfwords), ADDRESS=0x100, WRITE=0xCCCC_BBBB_AAAA, MEM_ACK tied 1 → MEM_K_WE high 3 cycles with (0x100,0xAAAA), (0x101,0xBBBB), (0x102,0xCCCC); HANDSHAKE=1 at cycle 4; MEM_P_WE stays 0.
2. CTRL=3'b001 (pic, 1 halfword), ADDRESS=0x20, WRITE low=0x1234, ACK delayed 5 cycles → MEM_P_WE with 0x20/0x1234 held stable 6 cycles; HANDSHAKE next cycle; released one cycle after ENABLE low.
3. ADDRESS=0xFFFF_FFFF, CTRL=3'b010 (2 halfwords) → second write at address 0x0000_0000.
4. MEM_ACK held 0, ACK_TIMEOUT=15 → WE drops after 15 cycles, ERROR=1, HANDSHAKE=0; ENABLE low → ERROR=0, IDLE.
5. ENABLE dropped after first ACK of a 3-halfword store, with ACK on the same edge → WE low next cycle, no further writes, no HANDSHAKE; a new request then proceeds normally.
6. RESET pulsed low asynchronously mid-ISSUE (between edges) → all outputs 0 immediately; no WE after release until a new ENABLE.
